button_event_ctrl: RTL and testbench

- Front-end controller for the board pushbuttons.
- Runs one shared sample-tick prescaler and debounces N raw buttons on that tick. Release is immediate; press must be stable for a set number of ticks.
- Detects press, release and long-press per button.
- A round-robin arbiter serialises all events onto one valid/ready event port read by the downstream control FSM.

---
 rtl/button_event_ctrl_if.sv | 13 +
 rtl/button_event_ctrl.sv | 171 +++++++++++++++++
 tb/tb_button_event_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/button_event_ctrl_if.sv
// Event port between the button front-end and the downstream control FSM.
// Master drives the event; slave accepts it with evt_ready.
interface button_event_ctrl_if #(
  parameter int ID_W = 2
);
  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;
  logic [1:0]      evt_kind;

  modport master (output evt_valid, evt_id, evt_kind, input evt_ready);
  modport slave  (input evt_valid, evt_id, evt_kind, output evt_ready);
endinterface

// File: rtl/button_event_ctrl.sv
// Pushbutton front-end: shared sample-tick prescaler, per-button debounce,
// press/release/long-press detection and round-robin event serialisation.
module button_event_ctrl #(
  parameter int N_BTN      = 4,
  parameter int TICK_DIV   = 50000,
  parameter int STABLE_CNT = 7,
  parameter int LONG_CNT   = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_BTN-1:0]        raw,
  output logic [N_BTN-1:0]        clean,
  output logic                    tick,
  output logic                    overflow,
  button_event_ctrl_if.master     evt
);

  localparam int ID_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int PW   = $clog2(TICK_DIV);
  localparam int SW   = $clog2(STABLE_CNT + 1);
  localparam int LW   = $clog2(LONG_CNT + 1);

  typedef enum logic [1:0] {
    KIND_PRESS   = 2'b00,
    KIND_RELEASE = 2'b01,
    KIND_LONG    = 2'b10
  } kind_e;

  logic [PW-1:0]    pcnt;
  logic [SW-1:0]    scnt [N_BTN];
  logic [LW-1:0]    lcnt [N_BTN];

  logic [N_BTN-1:0] ev_press, ev_rel, ev_long;
  logic [N_BTN-1:0] pend_p, pend_r, pend_l;
  logic [N_BTN-1:0] clr_p, clr_r, clr_l;
  logic [N_BTN-1:0] any_pend;

  logic             valid_q;
  logic [ID_W-1:0]  id_q;
  kind_e            kind_q;
  logic [ID_W-1:0]  ptr;

  logic             free, found, load;
  logic [ID_W-1:0]  gnt_idx;
  kind_e            gnt_kind;
  logic [ID_W:0]    cand;
  logic             drop;

  assign evt.evt_valid = valid_q;
  assign evt.evt_id    = id_q;
  assign evt.evt_kind  = kind_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (pcnt == PW'(TICK_DIV - 1));
      pcnt <= (pcnt == PW'(TICK_DIV - 1)) ? '0 : pcnt + 1'b1;
    end
  end

  // Events are decoded from the current state so they land on the same edge
  // as the clean / long-counter transition they describe.
  always_comb begin
    ev_press = '0;
    ev_rel   = '0;
    ev_long  = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      ev_press[i] = raw[i] & tick & ~clean[i] & (scnt[i] == SW'(STABLE_CNT - 1));
      ev_rel[i]   = clean[i] & ~raw[i];
      ev_long[i]  = clean[i] & raw[i] & tick & (lcnt[i] == LW'(LONG_CNT - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clean <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        scnt[i] <= '0;
        lcnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (!raw[i]) begin
          scnt[i]  <= '0;
          lcnt[i]  <= '0;
          clean[i] <= 1'b0;
        end else begin
          if (tick && scnt[i] != SW'(STABLE_CNT))
            scnt[i] <= scnt[i] + 1'b1;
          if (ev_press[i])
            clean[i] <= 1'b1;
          if (clean[i] && tick && lcnt[i] != LW'(LONG_CNT))
            lcnt[i] <= lcnt[i] + 1'b1;
        end
      end
    end
  end

  assign any_pend = pend_p | pend_r | pend_l;
  assign free     = ~valid_q | evt.evt_ready;

  // Round-robin search starting at ptr; the first button with any pending
  // bit wins, then press > long > release within that button.
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    cand     = '0;
    gnt_kind = KIND_PRESS;
    for (int unsigned off = 0; off < N_BTN; off++) begin
      cand = {1'b0, ptr} + (ID_W + 1)'(off);
      if (cand >= (ID_W + 1)'(N_BTN))
        cand = cand - (ID_W + 1)'(N_BTN);
      if (!found && any_pend[cand[ID_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[ID_W-1:0];
      end
    end
    if (pend_p[gnt_idx])      gnt_kind = KIND_PRESS;
    else if (pend_l[gnt_idx]) gnt_kind = KIND_LONG;
    else                      gnt_kind = KIND_RELEASE;
  end

  assign load = free & found;

  always_comb begin
    clr_p = '0;
    clr_r = '0;
    clr_l = '0;
    if (load) begin
      case (gnt_kind)
        KIND_PRESS: clr_p[gnt_idx] = 1'b1;
        KIND_LONG:  clr_l[gnt_idx] = 1'b1;
        default:    clr_r[gnt_idx] = 1'b1;
      endcase
    end
  end

  assign drop = |((pend_p & ~clr_p) & ev_press)
              | |((pend_r & ~clr_r) & ev_rel)
              | |((pend_l & ~clr_l) & ev_long);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_p   <= '0;
      pend_r   <= '0;
      pend_l   <= '0;
      overflow <= 1'b0;
      valid_q  <= 1'b0;
      id_q     <= '0;
      kind_q   <= KIND_PRESS;
      ptr      <= '0;
    end else begin
      pend_p <= (pend_p & ~clr_p) | ev_press;
      pend_r <= (pend_r & ~clr_r) | ev_rel;
      pend_l <= (pend_l & ~clr_l) | ev_long;
      if (drop)
        overflow <= 1'b1;
      if (load) begin
        valid_q <= 1'b1;
        id_q    <= gnt_idx;
        kind_q  <= gnt_kind;
        ptr     <= (gnt_idx == ID_W'(N_BTN - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (free) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_button_event_ctrl;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int SC = 3;
  localparam int LC = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] raw = '0;
  logic [N-1:0] clean;
  logic         tick;
  logic         overflow;

  button_event_ctrl_if #(.ID_W(2)) bif ();

  button_event_ctrl #(
    .N_BTN(N), .TICK_DIV(TD), .STABLE_CNT(SC), .LONG_CNT(LC)
  ) dut (
    .clk(clk), .rst(rst), .raw(raw), .clean(clean), .tick(tick),
    .overflow(overflow), .evt(bif.master)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: tick from the cycle number since reset, counters as
  // plain integers, pending events as a [button][kind] bit table.
  int m_cyc, m_sc[N], m_lc[N], m_id, m_kind, m_ptr;
  bit m_clean[N], m_pend[N][3], m_valid, m_tick, m_ovf, started;
  int prio[3] = '{0, 2, 1};

  always @(posedge clk) begin
    bit t, nclean, found;
    int nsc, nlc, j;
    bit ev[N][3];
    if (rst) begin
      m_cyc = 0; m_valid = 0; m_id = 0; m_kind = 0; m_ptr = 0; m_ovf = 0;
      for (int i = 0; i < N; i++) begin
        m_sc[i] = 0; m_lc[i] = 0; m_clean[i] = 0;
        for (int k = 0; k < 3; k++) m_pend[i][k] = 0;
      end
      started = 1;
    end else if (started) begin
      t = (m_cyc > 0) && (m_cyc % TD == 0);
      for (int i = 0; i < N; i++) begin
        if (!raw[i]) begin
          nsc = 0; nclean = 0;
        end else if (t) begin
          nsc = (m_sc[i] + 1 > SC) ? SC : m_sc[i] + 1;
          nclean = (nsc == SC);
        end else begin
          nsc = m_sc[i]; nclean = m_clean[i];
        end
        if (!nclean)                nlc = 0;
        else if (m_clean[i] && t)   nlc = (m_lc[i] + 1 > LC) ? LC : m_lc[i] + 1;
        else                        nlc = m_lc[i];
        ev[i][0] = !m_clean[i] && nclean;
        ev[i][1] = m_clean[i] && !nclean;
        ev[i][2] = (m_lc[i] < LC) && (nlc == LC);
        m_sc[i] = nsc; m_lc[i] = nlc; m_clean[i] = nclean;
      end
      if (!m_valid || bif.evt_ready) begin
        found = 0;
        for (int off = 0; off < N; off++) begin
          j = (m_ptr + off) % N;
          for (int p = 0; p < 3; p++)
            if (!found && m_pend[j][prio[p]]) begin
              found = 1; m_id = j; m_kind = prio[p];
              m_pend[j][prio[p]] = 0;
            end
        end
        m_valid = found;
        if (found) m_ptr = (m_id + 1) % N;
      end
      for (int i = 0; i < N; i++)
        for (int k = 0; k < 3; k++)
          if (ev[i][k]) begin
            if (m_pend[i][k]) m_ovf = 1;
            m_pend[i][k] = 1;
          end
      m_cyc++;
    end
    m_tick = (m_cyc > 0) && (m_cyc % TD == 0);
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < N; i++) check($sformatf("model clean[%0d]", i), 32'(clean[i]), 32'(m_clean[i]));
      check("model tick", 32'(tick), 32'(m_tick));
      check("model evt_valid", 32'(bif.evt_valid), 32'(m_valid));
      check("model overflow", 32'(overflow), 32'(m_ovf));
      if (m_valid) begin
        check("model evt_id", 32'(bif.evt_id), 32'(m_id));
        check("model evt_kind", 32'(bif.evt_kind), 32'(m_kind));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic adv_to(input int c);
    while (cyc < c) begin
      @(posedge clk); #2;
      cyc++;
    end
  endtask

  initial begin
    bif.evt_ready = 1'b1;

    // Clean press on button 0
    raw = 4'b0001;
    do_reset();
    check("reset valid", 32'(bif.evt_valid), 0);
    check("reset overflow", 32'(overflow), 0);
    check("reset clean", 32'(clean), 0);
    check("reset tick", 32'(tick), 0);
    check("reset id", 32'(bif.evt_id), 0);
    check("reset kind", 32'(bif.evt_kind), 0);
    adv_to(3);  check("tick c3", 32'(tick), 0);
    adv_to(4);  check("tick c4", 32'(tick), 1);
    adv_to(8);  check("tick c8", 32'(tick), 1);
    adv_to(12); check("tick c12", 32'(tick), 1); check("clean0 c12", 32'(clean[0]), 0);
    adv_to(13); check("clean0 c13", 32'(clean[0]), 1); check("valid c13", 32'(bif.evt_valid), 0);
    adv_to(14); check("valid c14", 32'(bif.evt_valid), 1);
    check("id c14", 32'(bif.evt_id), 0); check("kind c14", 32'(bif.evt_kind), 0);
    adv_to(15); check("valid c15", 32'(bif.evt_valid), 0);

    // Long press then release on button 2
    raw = 4'b0100;
    do_reset();
    adv_to(14); check("lp press id", 32'(bif.evt_id), 2); check("lp press kind", 32'(bif.evt_kind), 0);
    adv_to(45); check("lp valid c45", 32'(bif.evt_valid), 0);
    adv_to(46); check("lp long valid", 32'(bif.evt_valid), 1);
    check("lp long id", 32'(bif.evt_id), 2); check("lp long kind", 32'(bif.evt_kind), 2);
    adv_to(50); raw = 4'b0000;
    adv_to(51); check("lp clean2 drop", 32'(clean[2]), 0); check("lp valid c51", 32'(bif.evt_valid), 0);
    adv_to(52); check("lp rel valid", 32'(bif.evt_valid), 1); check("lp rel kind", 32'(bif.evt_kind), 1);

    // Bounce on button 1
    raw = 4'b0000;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      raw[1] = ((k / 3) % 2 == 0);
      adv_to(cyc + 1);
    end
    raw = 4'b0000;
    adv_to(cyc + 10);
    check("bounce clean", 32'(clean), 0);
    check("bounce valid", 32'(bif.evt_valid), 0);
    check("bounce overflow", 32'(overflow), 0);

    // Round-robin across buttons 0, 1, 3
    bif.evt_ready = 1'b0;
    raw = 4'b1011;
    do_reset();
    adv_to(14); check("rr id0", 32'(bif.evt_id), 0); check("rr valid c14", 32'(bif.evt_valid), 1);
    adv_to(15); check("rr hold id0", 32'(bif.evt_id), 0);
    bif.evt_ready = 1'b1;
    adv_to(16); check("rr id1", 32'(bif.evt_id), 1);
    adv_to(17); check("rr id3", 32'(bif.evt_id), 3);
    adv_to(18); check("rr valid c18", 32'(bif.evt_valid), 0);
    raw = 4'b0000;
    adv_to(20); check("rr2 id0", 32'(bif.evt_id), 0); check("rr2 kind", 32'(bif.evt_kind), 1);
    adv_to(21); check("rr2 id1", 32'(bif.evt_id), 1);
    adv_to(22); check("rr2 id3", 32'(bif.evt_id), 3);

    // Backpressure and overflow on button 3, then reset mid-operation
    bif.evt_ready = 1'b0;
    raw = 4'b1000;
    do_reset();
    adv_to(14); check("bp id", 32'(bif.evt_id), 3); check("bp kind", 32'(bif.evt_kind), 0);
    adv_to(16); raw = 4'b0000;
    adv_to(18); raw = 4'b1000;
    adv_to(29); check("bp no ovf", 32'(overflow), 0);
    adv_to(30); raw = 4'b0000;
    adv_to(31); check("bp ovf", 32'(overflow), 1);
    check("bp stall valid", 32'(bif.evt_valid), 1);
    check("bp stall id", 32'(bif.evt_id), 3); check("bp stall kind", 32'(bif.evt_kind), 0);
    adv_to(32); raw = 4'b1001;
    adv_to(46); check("pre-rst clean0", 32'(clean[0]), 1);
    do_reset();
    check("mid-rst valid", 32'(bif.evt_valid), 0);
    check("mid-rst overflow", 32'(overflow), 0);
    check("mid-rst clean", 32'(clean), 0);
    adv_to(12); check("requal clean0 c12", 32'(clean[0]), 0);
    adv_to(13); check("requal clean0 c13", 32'(clean[0]), 1);

    // Randomized traffic
    for (int run = 0; run < 4; run++) begin
      raw = N'($urandom);
      do_reset();
      for (int k = 0; k < 2500; k++) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 23) == 0) raw[i] = ~raw[i];
        bif.evt_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1499) == 0) do_reset();
        else adv_to(cyc + 1);
      end
    end

    adv_to(cyc + 2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
